shift_hold_tx: RTL and testbench

//   Parallel-to-serial transmitter that drives a shift-N/hold-M gated serial link.

---
 rtl/shift_hold_tx_pkg.sv | 18 +
 rtl/shift_hold_phase_ctr.sv | 40 ++++
 rtl/shift_hold_tx.sv | 124 ++++++++++++
 tb/tb_shift_hold_tx.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/shift_hold_tx_pkg.sv
// FSM encodings and link defaults shared by the shift/hold transmitter
// and the shift/hold receivers on the same link.
package shift_hold_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam int DEF_SHIFT = 2;
    localparam int DEF_HOLD  = 2;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/shift_hold_phase_ctr.sv
// Load/terminal-count phase counter: times one shift run or one hold gap.
// phase_end flags the final cycle of the currently loaded phase.
module shift_hold_phase_ctr
    import shift_hold_tx_pkg::*;
#(
    parameter int S = DEF_SHIFT,
    parameter int H = DEF_HOLD
) (
    input  logic clk,
    input  logic rst,
    input  logic load_shift,
    input  logic load_hold,
    output logic in_shift,
    output logic phase_end
);

    localparam int PW = $clog2(max_int(S, H) + 1);
    localparam logic [PW-1:0] S_LD = PW'(S - 1);
    localparam logic [PW-1:0] H_LD = PW'((H > 0) ? H - 1 : 0);

    logic [PW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt      <= '0;
            in_shift <= 1'b0;
        end else if (load_shift) begin
            cnt      <= S_LD;
            in_shift <= 1'b1;
        end else if (load_hold) begin
            cnt      <= H_LD;
            in_shift <= 1'b0;
        end else if (cnt != '0) begin
            cnt <= cnt - PW'(1);
        end
    end

    assign phase_end = (cnt == '0);

endmodule

// File: rtl/shift_hold_tx.sv
// Shift-N/hold-M serial transmitter, MSB first, valid/ready word input.
// Define SHIFT_HOLD_PARITY_EN to append an even-parity slot after the LSB.
module shift_hold_tx
    import shift_hold_tx_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int SHIFT_CYCLES = DEF_SHIFT,
    parameter int HOLD_CYCLES  = DEF_HOLD
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic             ser_out,
    output logic             ser_vld,
    output logic             busy
);

`ifdef SHIFT_HOLD_PARITY_EN
    localparam int NBITS = WIDTH + 1;
`else
    localparam int NBITS = WIDTH;
`endif
    localparam int BCW = $clog2(NBITS + 1);

    state_t           state, state_nx;
    logic [NBITS-1:0] sreg, sreg_nx;
    logic [NBITS-1:0] word;
    logic [BCW-1:0]   bits_left, bits_left_nx;
    logic             ser_out_nx, ser_vld_nx;
    logic             load_shift, load_hold;
    logic             in_shift, phase_end;
    logic             accept;

`ifdef SHIFT_HOLD_PARITY_EN
    assign word = {s_data, ^s_data};
`else
    assign word = s_data;
`endif

    assign accept = s_valid & s_ready;

    shift_hold_phase_ctr #(
        .S(SHIFT_CYCLES),
        .H(HOLD_CYCLES)
    ) u_phase (
        .clk       (clk),
        .rst       (rst),
        .load_shift(load_shift),
        .load_hold (load_hold),
        .in_shift  (in_shift),
        .phase_end (phase_end)
    );

    always_comb begin
        state_nx     = state;
        sreg_nx      = sreg;
        bits_left_nx = bits_left;
        ser_out_nx   = ser_out;
        ser_vld_nx   = 1'b0;
        load_shift   = 1'b0;
        load_hold    = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nx     = SHIFT;
                    ser_out_nx   = word[NBITS-1];
                    ser_vld_nx   = 1'b1;
                    sreg_nx      = word << 1;
                    bits_left_nx = BCW'(NBITS - 1);
                    load_shift   = 1'b1;
                end
            end
            SHIFT: begin
                // last slot just shown: finish without a trailing hold
                if (bits_left == '0) begin
                    state_nx = IDLE;
                end else if (in_shift && phase_end && HOLD_CYCLES > 0) begin
                    state_nx  = HOLD;
                    load_hold = 1'b1;
                end else begin
                    ser_out_nx   = sreg[NBITS-1];
                    ser_vld_nx   = 1'b1;
                    sreg_nx      = sreg << 1;
                    bits_left_nx = bits_left - BCW'(1);
                    load_shift   = phase_end;
                end
            end
            HOLD: begin
                if (phase_end) begin
                    state_nx     = SHIFT;
                    ser_out_nx   = sreg[NBITS-1];
                    ser_vld_nx   = 1'b1;
                    sreg_nx      = sreg << 1;
                    bits_left_nx = bits_left - BCW'(1);
                    load_shift   = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            sreg      <= '0;
            bits_left <= '0;
            ser_out   <= 1'b0;
            ser_vld   <= 1'b0;
            s_ready   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nx;
            sreg      <= sreg_nx;
            bits_left <= bits_left_nx;
            ser_out   <= ser_out_nx;
            ser_vld   <= ser_vld_nx;
            s_ready   <= (state_nx == IDLE);
            busy      <= (state_nx != IDLE);
        end
    end

endmodule

// File: tb/tb_shift_hold_tx.sv
// Randomised bench for shift_hold_tx: two instances (S=2/H=2 and S=3/H=0)
// checked every cycle against a slot-schedule reference model.
module tb_shift_hold_tx;

    localparam int W = 8;
`ifdef SHIFT_HOLD_PARITY_EN
    localparam int NB = W + 1;
`else
    localparam int NB = W;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]        rst;
    logic [1:0][W-1:0] s_data;
    logic [1:0]        s_valid;
    logic [1:0]        s_ready;
    logic [1:0]        ser_out;
    logic [1:0]        ser_vld;
    logic [1:0]        busy;

    shift_hold_tx #(.WIDTH(W), .SHIFT_CYCLES(2), .HOLD_CYCLES(2)) dut0 (
        .clk(clk), .rst(rst[0]), .s_data(s_data[0]), .s_valid(s_valid[0]),
        .s_ready(s_ready[0]), .ser_out(ser_out[0]), .ser_vld(ser_vld[0]),
        .busy(busy[0])
    );

    shift_hold_tx #(.WIDTH(W), .SHIFT_CYCLES(3), .HOLD_CYCLES(0)) dut1 (
        .clk(clk), .rst(rst[1]), .s_data(s_data[1]), .s_valid(s_valid[1]),
        .s_ready(s_ready[1]), .ser_out(ser_out[1]), .ser_vld(ser_vld[1]),
        .busy(busy[1])
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    int            ss [2] = '{2, 3};
    int            hh [2] = '{2, 0};
    bit            act [2];
    int            t0 [2];
    logic [NB-1:0] mword [2];
    logic          e_out [2];
    logic          e_vld [2];
    logic          e_rdy [2];
    logic          e_busy [2];
    int            vcnt [2];
    logic [31:0]   rx [2];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    function automatic logic [NB-1:0] frame_word(input logic [W-1:0] d);
`ifdef SHIFT_HOLD_PARITY_EN
        return {d, ^d};
`else
        return d;
`endif
    endfunction

    // Expected outputs for the cycle that just began, from the slot formula
    task automatic model(input int i);
        int d, p, k, last;
        if (!rst[i]) begin
            act[i]    = 1'b0;
            e_out[i]  = 1'b0;
            e_vld[i]  = 1'b0;
            e_rdy[i]  = 1'b0;
            e_busy[i] = 1'b0;
            return;
        end
        if (!act[i] && s_valid[i] && e_rdy[i]) begin
            act[i]   = 1'b1;
            t0[i]    = cyc - 1;
            mword[i] = frame_word(s_data[i]);
        end
        e_vld[i] = 1'b0;
        if (act[i]) begin
            d = cyc - t0[i] - 1;
            p = d % (ss[i] + hh[i]);
            k = (d / (ss[i] + hh[i])) * ss[i] + p;
            if (p < ss[i] && k < NB) begin
                e_vld[i] = 1'b1;
                e_out[i] = mword[i][NB-1-k];
            end
            last = t0[i] + 1 + ((NB - 1) / ss[i]) * (ss[i] + hh[i])
                   + ((NB - 1) % ss[i]);
            if (cyc > last) act[i] = 1'b0;
        end
        e_rdy[i]  = !act[i];
        e_busy[i] = act[i];
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < 2; i++) begin
            model(i);
            check($sformatf("d%0d.ser_vld", i), 32'(ser_vld[i]), 32'(e_vld[i]));
            check($sformatf("d%0d.ser_out", i), 32'(ser_out[i]), 32'(e_out[i]));
            check($sformatf("d%0d.s_ready", i), 32'(s_ready[i]), 32'(e_rdy[i]));
            check($sformatf("d%0d.busy", i), 32'(busy[i]), 32'(e_busy[i]));
            if (ser_vld[i]) begin
                vcnt[i]++;
                rx[i] = {rx[i][30:0], ser_out[i]};
            end
        end
    endtask

    task automatic wait_ready(input int i, input int budget, output int n);
        n = 0;
        while (!s_ready[i] && n < budget) begin
            tick();
            n++;
        end
        if (!s_ready[i]) check($sformatf("d%0d.timeout", i), 32'd0, 32'd1);
    endtask

    task automatic send(input int i, input logic [W-1:0] d);
        s_data[i]  = d;
        s_valid[i] = 1'b1;
        tick();
        s_valid[i] = 1'b0;
    endtask

    initial begin
        int n, v0, gap;
        for (int i = 0; i < 2; i++) begin
            act[i] = 0; t0[i] = 0; mword[i] = '0; vcnt[i] = 0; rx[i] = '0;
            e_out[i] = 0; e_vld[i] = 0; e_rdy[i] = 0; e_busy[i] = 0;
        end
        rst     = 2'b00;
        s_valid = 2'b11;
        s_data  = {8'hA5, 8'hA5};

        // Reset held with s_valid high: nothing may be accepted
        repeat (3) tick();
        check("rst.vld_count", 32'(vcnt[0] + vcnt[1]), 32'd0);
        rst     = 2'b11;
        s_valid = 2'b00;
        tick();

        // Single word, cadence S=2 H=2
        rx[0] = '0;
        send(0, 8'hA5);
        wait_ready(0, 40, gap);
        check("a5.ready_gap", 32'(gap),
              32'(((NB - 1) / 2) * 4 + ((NB - 1) % 2) + 1));
        check("a5.bits", rx[0] & ((32'd1 << NB) - 1), 32'(frame_word(8'hA5)));

        // Back-to-back words with s_valid held high
        rx[0] = '0;
        v0 = vcnt[0];
        s_data[0]  = 8'hFF;
        s_valid[0] = 1'b1;
        tick();
        s_data[0] = 8'h00;
        wait_ready(0, 40, n);
        tick();
        s_valid[0] = 1'b0;
        wait_ready(0, 40, n);
        check("b2b.slots", 32'(vcnt[0] - v0), 32'(2 * NB));
        check("b2b.bits", rx[0] & ((32'd1 << (2 * NB)) - 1),
              32'({frame_word(8'hFF), frame_word(8'h00)}));

        // Reset in the middle of a word
        v0 = vcnt[0];
        send(0, 8'hA5);
        repeat (4) tick();
        rst[0] = 1'b0;
        tick();
        rst[0] = 1'b1;
        v0 = vcnt[0];
        repeat (30) tick();
        check("midrst.no_pulses", 32'(vcnt[0] - v0), 32'd0);

        // Continuous stream, S=3 H=0
        rx[1] = '0;
        v0 = vcnt[1];
        send(1, 8'hC3);
        wait_ready(1, 40, gap);
        check("c3.slots", 32'(vcnt[1] - v0), 32'(NB));
        check("c3.ready_gap", 32'(gap), 32'(NB));
        check("c3.bits", rx[1] & ((32'd1 << NB) - 1), 32'(frame_word(8'hC3)));

        // Random traffic with occasional resets
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 2; i++) begin
                s_valid[i] = 1'($urandom_range(0, 1));
                s_data[i]  = W'($urandom);
                rst[i]     = ($urandom_range(0, 149) != 0);
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
